// File: rtl/edge_scan_reader.sv
// Sweeps a probe index range: clears the edge accumulator, lets it settle, reads all
// 128 result words through the bank/word selects and streams them out valid/ready.
module edge_scan_reader #(
  parameter int IDX_W      = 14,
  parameter int SETTLE_CYC = 4,
  parameter int RD_LAT     = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [IDX_W-1:0] idx_first,
  input  logic [IDX_W-1:0] idx_last,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] slv_reg0,
  output logic             acc_clr,
  output logic [2:0]       sel1,
  output logic [7:0]       sel2,
  input  logic [31:0]      result_imp,
  output logic [31:0]      m_data,
  output logic [IDX_W-1:0] m_idx,
  output logic [6:0]       m_word,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready
);

  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, READ, PUSH} state_t;

  localparam logic [7:0] SETTLE_END = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] READ_END   = 8'(RD_LAT - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] cur_idx_reg, last_idx_reg, slv_reg0_reg, m_idx_reg;
  logic [6:0]       word_ptr_reg, m_word_reg;
  logic [7:0]       cnt_reg;
  logic [31:0]      m_data_reg;
  logic             done_reg, err_reg, acc_clr_reg, m_valid_reg, m_last_reg;

  logic hs, range_ok, word_end, idx_end, settle_end, read_end;

  assign hs         = m_valid_reg & m_ready;
  assign range_ok   = idx_last >= idx_first;
  assign word_end   = word_ptr_reg == 7'd127;
  assign idx_end    = cur_idx_reg == last_idx_reg;
  assign settle_end = cnt_reg == SETTLE_END;
  assign read_end   = cnt_reg == READ_END;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && range_ok) state_next = CLEAR;
      CLEAR:   state_next = SETTLE;
      SETTLE:  if (settle_end) state_next = READ;
      READ:    if (read_end) state_next = PUSH;
      PUSH: begin
        if (hs) begin
          if (!word_end)     state_next = READ;
          else if (!idx_end) state_next = CLEAR;
          else               state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      cur_idx_reg  <= '0;
      last_idx_reg <= '0;
      slv_reg0_reg <= '0;
      word_ptr_reg <= '0;
      cnt_reg      <= '0;
      m_data_reg   <= '0;
      m_idx_reg    <= '0;
      m_word_reg   <= '0;
      m_last_reg   <= 1'b0;
      m_valid_reg  <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      acc_clr_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      acc_clr_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (range_ok) begin
              // Outputs that belong to CLEAR are registered on the way in.
              cur_idx_reg  <= idx_first;
              last_idx_reg <= idx_last;
              slv_reg0_reg <= idx_first;
              acc_clr_reg  <= 1'b1;
              word_ptr_reg <= '0;
              cnt_reg      <= '0;
            end else begin
              done_reg <= 1'b1;
              err_reg  <= 1'b1;
            end
          end
        end
        CLEAR: cnt_reg <= '0;
        SETTLE: cnt_reg <= settle_end ? 8'd0 : cnt_reg + 8'd1;
        READ: begin
          if (read_end) begin
            cnt_reg     <= '0;
            m_data_reg  <= result_imp;
            m_idx_reg   <= cur_idx_reg;
            m_word_reg  <= word_ptr_reg;
            m_last_reg  <= word_end && idx_end;
            m_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        PUSH: begin
          if (hs) begin
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            if (!word_end) begin
              word_ptr_reg <= word_ptr_reg + 7'd1;
            end else if (!idx_end) begin
              // Compare happened above, so the increment can never wrap past idx_last.
              cur_idx_reg  <= cur_idx_reg + 1'b1;
              slv_reg0_reg <= cur_idx_reg + 1'b1;
              acc_clr_reg  <= 1'b1;
              word_ptr_reg <= '0;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = state_reg != IDLE;
  assign done     = done_reg;
  assign err      = err_reg;
  assign slv_reg0 = slv_reg0_reg;
  assign acc_clr  = acc_clr_reg;
  assign sel1     = word_ptr_reg[6:4];
  assign sel2     = {4'b0000, word_ptr_reg[3:0]};
  assign m_data   = m_data_reg;
  assign m_idx    = m_idx_reg;
  assign m_word   = m_word_reg;
  assign m_last   = m_last_reg;
  assign m_valid  = m_valid_reg;

endmodule

// File: doc/edge_scan_reader.md
Name: edge_scan_reader

Overview:
- Initiator/reader for the edge-mask accumulator and readout block.
- Drives the probe index (slv_reg0) and pulses an accumulator clear.
- Drives the bank/word selects (sel1/sel2) across all 128 32-bit words of the 4096-bit sticky edge result. Captures result_imp for each word.
- Streams each captured word out on a valid/ready interface, tagged with index and word number, so software/DMA can dump a full index sweep unattended.

Parameters:
- IDX_W, 14, width of probe index ({x[3:0],y[4:0],z[4:0]}).
- SETTLE_CYC, 4, cycles the accumulator collects masks after clear before readout; legal range 1..255.
- RD_LAT, 2, cycles from a select change to result_imp valid; legal range 1..7.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- idx_first  in  IDX_W  first index of sweep; sampled with start.
- idx_last  in  IDX_W  last index of sweep, inclusive; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sweep completes or is rejected.
- err  out  1  one-cycle pulse, coincident with done, when the range is rejected.
- slv_reg0  out  IDX_W  probe index to the accumulator block.
- acc_clr  out  1  one-cycle clear pulse to the accumulator.
- sel1  out  3  bank select (word_ptr[6:4]).
- sel2  out  8  word-in-bank select, {4'b0, word_ptr[3:0]}.
- result_imp  in  32  selected word from the accumulator.
- m_data  out  32  captured word.
- m_idx  out  IDX_W  index the word belongs to.
- m_word  out  7  word number 0..127; bit0 of word N = edge bit 32*N.
- m_last  out  1  high with the final word of the sweep.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts when m_valid & m_ready.

Behaviour:
- Reset values:
  - state=IDLE; busy=0, done=0, err=0, acc_clr=0, m_valid=0, m_last=0.
  - slv_reg0=0, sel1=0, sel2=0, m_data=0, m_idx=0, m_word=0.
  - Counters are 0.
- Reset mid-sweep: return to IDLE next edge; any pending m_valid drops without handshake; no done pulse.
- IDLE:
  - start=1 with idx_last >= idx_first: latch the range, cur_idx=idx_first, go to CLEAR.
  - start=1 with idx_last < idx_first: pulse done=1 and err=1 next cycle, stay IDLE, no outputs change.
- CLEAR (1 cycle): slv_reg0=cur_idx, acc_clr=1, word_ptr=0. Then SETTLE.
- SETTLE: count SETTLE_CYC cycles with acc_clr=0; slv_reg0 held. Then READ.
- READ: sel1/sel2 reflect word_ptr. Wait RD_LAT cycles, then capture result_imp into m_data and go to PUSH.
- PUSH:
  - m_valid=1; m_data/m_idx/m_word/m_last stable until handshake.
  - m_last=1 iff word_ptr=127 and cur_idx=idx_last.
- On handshake in PUSH:
  - word_ptr<127: word_ptr+1, go to READ; m_valid=0 next cycle.
  - word_ptr=127 and cur_idx<idx_last: cur_idx+1, go to CLEAR.
  - word_ptr=127 and cur_idx=idx_last: go to IDLE with done=1 for 1 cycle; busy=0 the same cycle.
- Latency: start accepted at edge T → acc_clr high in cycle T+1 → first m_valid in cycle T+2+SETTLE_CYC+RD_LAT. Defaults give T+8.
- Throughput with m_ready held high: one word per RD_LAT+1 cycles.
- m_ready low stalls indefinitely with no data loss. m_ready is ignored when m_valid=0.
- Index compare happens before increment. idx_last=2^IDX_W-1 terminates with no wrap to 0.
- start while busy is ignored; the latched range does not change.
- Total words per sweep = (idx_last-idx_first+1)*128. m_last is asserted exactly once per sweep.
- sel2[7:4] are always 0.

Test Plan:
- Single index: idx_first=idx_last=0x0005, result_imp model returns {idx,word}, m_ready=1.
  - Expect acc_clr at T+1, first m_valid at T+8.
  - Expect 128 words with m_word 0..127 and m_idx=5.
  - Expect m_last only on word 127, then a done pulse with err=0.
- Range 0x3FFE..0x3FFF: expect 256 words, two acc_clr pulses, slv_reg0 0x3FFE then 0x3FFF, no wrap to 0, done once.
- Backpressure: random m_ready with 30% duty over a 2-index sweep.
  - m_data stays stable while m_valid&!m_ready.
  - No word is dropped or duplicated; scoreboard matches 256 words.
- Reversed range: idx_first=10, idx_last=9 → next-cycle done=1, err=1, busy stays 0, no acc_clr, no m_valid.
- RST asserted during PUSH of word 40 with m_ready=0 → next cycle m_valid=0, busy=0, all outputs at reset values. A new start then sweeps from word 0.
- start pulsed again while busy with a different range → ignored; the original sweep completes with the original word count.
